// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit control path.
// STOP2 state is only reachable when UART_TX_STOP2_EN is defined.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StStop2
   } tx_state_e;

   localparam logic [1:0] MUX_START = 2'b00;
   localparam logic [1:0] MUX_STOP  = 2'b01;
   localparam logic [1:0] MUX_DATA  = 2'b10;
   localparam logic [1:0] MUX_PAR   = 2'b11;

   // Bit-counter width; kept at least 1 so a degenerate width still elaborates.
   function automatic int unsigned cnt_width(input int unsigned data_width);
      return (data_width > 1) ? $clog2(data_width) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter; emits bits LSB-first and flags the last one.
module uart_tx_serializer
   import uart_tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  load,
   input  logic                  shift_en,
   input  logic [DATA_WIDTH-1:0] p_data,
   output logic                  ser_data,
   output logic                  ser_done
);

   localparam int unsigned CNT_W = cnt_width(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   assign ser_data = shreg_q[0];
   assign ser_done = (cnt_q == LAST_BIT);

   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      if (load) begin
         shreg_d = p_data;
         cnt_d   = '0;
      end else if (shift_en) begin
         shreg_d = shreg_q >> 1;
         cnt_d   = ser_done ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit framing FSM: start, LSB-first data, optional parity, stop.
// Define UART_TX_STOP2_EN to add a second stop bit (accept then happens in STOP2).
module uart_tx_ctrl
   import uart_tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  DATA_VALID,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  ser_data,
   output logic                  PAR_BIT,
   output logic [1:0]            mux_sel,
   output logic                  busy
);

`ifdef UART_TX_STOP2_EN
   localparam tx_state_e LAST_STOP = StStop2;
`else
   localparam tx_state_e LAST_STOP = StStop;
`endif

   tx_state_e state_q, state_d;
   logic      par_bit_q, par_en_q;
   logic      accept, shift_en, ser_done;

   uart_tx_serializer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_serializer (
      .CLK      (CLK),
      .RST      (RST),
      .load     (accept),
      .shift_en (shift_en),
      .p_data   (P_DATA),
      .ser_data (ser_data),
      .ser_done (ser_done)
   );

   // New frames are only taken when the line is idle or in its final stop bit.
   assign accept  = DATA_VALID && (state_q == StIdle || state_q == LAST_STOP);
   assign PAR_BIT = par_bit_q;

   always_comb begin
      state_d  = state_q;
      shift_en = 1'b0;
      mux_sel  = MUX_STOP;
      busy     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) state_d = StStart;
         end
         StStart: begin
            mux_sel = MUX_START;
            busy    = 1'b1;
            state_d = StData;
         end
         StData: begin
            mux_sel  = MUX_DATA;
            busy     = 1'b1;
            shift_en = 1'b1;
            if (ser_done) state_d = par_en_q ? StParity : StStop;
         end
         StParity: begin
            mux_sel = MUX_PAR;
            busy    = 1'b1;
            state_d = StStop;
         end
         StStop: begin
            busy = 1'b1;
`ifdef UART_TX_STOP2_EN
            state_d = StStop2;
`else
            state_d = accept ? StStart : StIdle;
`endif
         end
`ifdef UART_TX_STOP2_EN
         StStop2: begin
            busy    = 1'b1;
            state_d = accept ? StStart : StIdle;
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= StIdle;
         par_bit_q <= 1'b0;
         par_en_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            par_bit_q <= (^P_DATA) ^ PAR_TYP;
            par_en_q  <= PAR_EN;
         end
      end
   end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Upstream control/datapath stage of the UART transmitter. Accepts a parallel byte, frames it (start, data LSB-first, optional parity, stop) and drives the output multiplexer stage.
- Produces `ser_data`, `PAR_BIT` and `mux_sel` for the registered output mux. `TX_OUT` therefore lags this block's `mux_sel` by exactly 1 CLK.
- One transmitted bit per CLK; CLK is the baud-rate transmit clock.

Parameters:
- DATA_WIDTH, 8, payload bits per frame (supported range 5..9).

Ports:
- CLK  in  1  transmit (baud) clock, rising-edge.
- RST  in  1  asynchronous, active-low reset.
- P_DATA  in  DATA_WIDTH  parallel payload.
- DATA_VALID  in  1  payload-valid strobe; a 1-cycle pulse or held high.
- PAR_EN  in  1  1 = insert parity bit.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- ser_data  out  1  current data bit to the mux.
- PAR_BIT  out  1  parity bit to the mux.
- mux_sel  out  2  00 = start (0), 01 = stop/idle (1), 10 = `ser_data`, 11 = `PAR_BIT`.
- busy  out  1  frame in progress.

Behaviour:
- **Clock and reset.** Single clock CLK. Reset RST is asynchronous and active-low.
- **Reset values.** State = IDLE, `mux_sel` = 01, `busy` = 0, `ser_data` = 0, `PAR_BIT` = 0, shift register = 0, bit counter = 0.
- **States:** IDLE, START, DATA, PARITY, STOP. Outputs are Moore, decoded from state plus datapath registers.
  - IDLE: `mux_sel` = 01, `busy` = 0.
  - START: `mux_sel` = 00, `busy` = 1.
  - DATA: `mux_sel` = 10, `busy` = 1.
  - PARITY: `mux_sel` = 11, `busy` = 1.
  - STOP: `mux_sel` = 01, `busy` = 1.
- **Accept.** accept = `DATA_VALID` && (state == IDLE || state == STOP).
  - On the accept edge: latch `P_DATA` into the shift register, and latch `PAR_EN`.
  - On the same edge, register `PAR_BIT` = (^`P_DATA`) ^ `PAR_TYP`.
  - Next state is START.
- **Ignored inputs while busy.** `DATA_VALID`, `P_DATA`, `PAR_EN` and `PAR_TYP` are ignored in START, DATA and PARITY. Latched values cannot change mid-frame.
- **START → DATA** after 1 cycle; bit counter is cleared to 0.
- **DATA.**
  - `ser_data` = shift register bit 0.
  - Shift right each cycle; counter increments.
  - After DATA_WIDTH cycles (counter == DATA_WIDTH-1): go to PARITY if latched `PAR_EN`, else STOP.
- **PARITY → STOP** after 1 cycle.
- **STOP.**
  - Accept asserted: go to START (back-to-back frames, no idle gap).
  - Otherwise: go to IDLE.
- **Frame length.** Start to end of stop = DATA_WIDTH + 2 cycles, + 1 if parity is enabled. Default with parity: 11 cycles.
- **Latency.** Accept edge → `mux_sel` = 00 on the next cycle → `TX_OUT` = 0 one cycle later.
- **Reset mid-frame.** Immediate return to reset values. After release, the block stays in IDLE until a new accept; there is no partial-frame resume.
- **DATA_VALID held high continuously.** Produces consecutive frames, each re-sampling `P_DATA` in STOP.

Optional Feature:
- Macro: UART_TX_STOP2_EN.
- Defined: adds a STOP2 state after STOP (`mux_sel` = 01, `busy` = 1, 1 cycle).
  - Accept is evaluated in STOP2 instead of STOP.
  - Frame length is +1 cycle; default with parity = 12.
- Undefined: single stop bit as above, and STOP2 logic is absent.

Decomposition:
- Package `uart_tx_pkg`:
  - State enum/localparams (IDLE, START, DATA, PARITY, STOP, STOP2).
  - Mux-select constants: MUX_START = 2'b00, MUX_STOP = 2'b01, MUX_DATA = 2'b10, MUX_PAR = 2'b11.
  - Counter width = $clog2(DATA_WIDTH).
- Sub-module `uart_tx_serializer`:
  - Contains the shift register and bit counter.
  - Inputs: load, shift enable, parallel data.
  - Outputs: `ser_data` and `ser_done`.
- The FSM and parity register stay in the top.

Test Plan:
1. **Reset.** Hold RST = 0 for 3 cycles → `mux_sel` = 01, `busy` = 0, `ser_data` = 0, `PAR_BIT` = 0.
2. **Even parity frame.** `P_DATA` = 0xA5, `PAR_EN` = 1, `PAR_TYP` = 0, 1-cycle `DATA_VALID`.
   - `mux_sel` sequence: 00, then 10 ×8, then 11, then 01.
   - `ser_data` = 1,0,1,0,0,1,0,1; `PAR_BIT` = 0.
   - `TX_OUT` = 0,1,0,1,0,0,1,0,1,0,1; `busy` high for 11 cycles.
3. **Odd parity, then no parity.**
   - `P_DATA` = 0x01, `PAR_TYP` = 1 → `PAR_BIT` = 0.
   - Repeat with `PAR_EN` = 0 → no 11 cycle; frame is 10 cycles.
4. **Back-to-back.** `DATA_VALID` held high with 0x55 then 0xFF presented in STOP → second START immediately follows STOP; the second frame carries 0xFF.
5. **Input change mid-frame.** Change `P_DATA`, `PAR_EN` and `PAR_TYP` during DATA → current frame bits unchanged.
6. **Reset mid-frame.** Assert RST in the 4th DATA cycle → `mux_sel` = 01 and `busy` = 0 asynchronously. After release, stays idle with no spurious start.
   - With UART_TX_STOP2_EN defined, rerun scenario 2 → two 01 cycles and a 12-cycle frame.
